stump_mem_sequencer: RTL and testbench

//  Parametrised fetch/execute/memory sequencer for the next-generation Stump core.

---
 rtl/stump_mem_sequencer_if.sv | 23 ++
 rtl/stump_mem_sequencer.sv | 171 +++++++++++++++++
 tb/tb_stump_mem_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/stump_mem_sequencer_if.sv
// rtl/stump_mem_sequencer_if.sv - memory request/acknowledge bus between sequencer and memory
interface stump_mem_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_out;
  logic              mem_ack;
  logic [DATA_W-1:0] data_in;

  modport master (
    output mem_req, mem_ren, mem_wen, address, data_out,
    input  mem_ack, data_in
  );

  modport slave (
    input  mem_req, mem_ren, mem_wen, address, data_out,
    output mem_ack, data_in
  );
endinterface

// File: rtl/stump_mem_sequencer.sv
// rtl/stump_mem_sequencer.sv - fetch/execute/memory sequencer with req/ack wait states, timeout and halt
module stump_mem_sequencer #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  halt_req,
  input  logic                  is_mem,
  input  logic                  is_store,
  input  logic [ADDR_W-1:0]     pc_addr,
  input  logic [ADDR_W-1:0]     ea,
  input  logic [DATA_W-1:0]     st_data,
  stump_mem_sequencer_if.master bus,
  output logic                  fetch,
  output logic                  execute,
  output logic                  memory,
  output logic                  ir_load,
  output logic [DATA_W-1:0]     ir,
  output logic                  reg_load,
  output logic [DATA_W-1:0]     load_data,
  output logic                  halted,
  output logic                  bus_err,
  output logic [CNT_W-1:0]      retired
);

  // Wide enough to hold MAX_WAIT; a disabled timeout still needs a 1-bit counter.
  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEMORY  = 3'd3,
    S_HALTED  = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ADDR_W-1:0] ea_q, ea_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              wr_q, wr_d;

  logic req_active;
  logic acked;
  logic timeout_hit;

  // A request is live only in FETCH/MEMORY; an ack outside those states is ignored.
  assign req_active  = (state_q == S_FETCH) || (state_q == S_MEMORY);
  assign acked       = req_active && bus.mem_ack;
  assign timeout_hit = (MAX_WAIT != 0) && (wait_q == WAIT_LIMIT);

  // State register; reset is asynchronous so an in-flight request drops at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an ack in the timeout cycle takes priority over the fault.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ack)      state_d = S_EXECUTE;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_EXECUTE: begin
        if (is_mem)        state_d = S_MEMORY;
        else if (halt_req) state_d = S_HALTED;
        else               state_d = S_FETCH;
      end
      S_MEMORY: begin
        if (bus.mem_ack)      state_d = halt_req ? S_HALTED : S_FETCH;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_HALTED: begin
        if (!halt_req) state_d = S_FETCH;
      end
      S_FAULT:   state_d = S_FAULT;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath registers: IR, load data, retire counter, wait counter, latched memory operands.
  always_comb begin
    ir_d        = ir_q;
    load_data_d = load_data_q;
    retired_d   = retired_q;
    wait_d      = wait_q;
    ea_d        = ea_q;
    wd_d        = wd_q;
    wr_d        = wr_q;

    if (state_q == S_FETCH && bus.mem_ack) begin
      ir_d = bus.data_in;
    end

    if (state_q == S_EXECUTE) begin
      ea_d = ea;
      wd_d = st_data;
      wr_d = is_store;
      if (!is_mem) retired_d = retired_q + CNT_W'(1);
    end

    if (state_q == S_MEMORY && bus.mem_ack) begin
      if (!wr_q) load_data_d = bus.data_in;
      retired_d = retired_q + CNT_W'(1);
    end

    if ((state_d != state_q) && (state_d == S_FETCH || state_d == S_MEMORY)) begin
      wait_d = '0;
    end else if (req_active && !acked && (wait_q != {WAIT_W{1'b1}})) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // Datapath register bank, cleared by the same asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_q        <= '0;
      load_data_q <= '0;
      retired_q   <= '0;
      wait_q      <= '0;
      ea_q        <= '0;
      wd_q        <= '0;
      wr_q        <= 1'b0;
    end else begin
      ir_q        <= ir_d;
      load_data_q <= load_data_d;
      retired_q   <= retired_d;
      wait_q      <= wait_d;
      ea_q        <= ea_d;
      wd_q        <= wd_d;
      wr_q        <= wr_d;
    end
  end

  // Phase strobes and bus controls decoded from the current state.
  always_comb begin
    fetch        = (state_q == S_FETCH);
    execute      = (state_q == S_EXECUTE);
    memory       = (state_q == S_MEMORY);
    halted       = (state_q == S_HALTED);
    bus_err      = (state_q == S_FAULT);
    bus.mem_req  = req_active;
    bus.mem_ren  = fetch || (memory && !wr_q);
    bus.mem_wen  = memory && wr_q;
    bus.address  = '0;
    if (fetch)  bus.address = pc_addr;
    if (memory) bus.address = ea_q;
    ir_load      = fetch && bus.mem_ack;
    reg_load     = memory && bus.mem_ack && !wr_q;
  end

  assign bus.data_out = wd_q;
  assign ir           = ir_q;
  assign load_data    = load_data_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_stump_mem_sequencer.sv
// tb/tb_stump_mem_sequencer.sv - directed vector bench for stump_mem_sequencer
module tb_stump_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt_req, is_mem, is_store;
  logic [15:0] pc_addr, ea, st_data;
  logic        fetch, execute, memory, ir_load, reg_load, halted, bus_err;
  logic [15:0] ir, load_data;
  logic [31:0] retired;

  int checks = 0;
  int passes = 0;

  stump_mem_sequencer_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  stump_mem_sequencer #(
    .DATA_W(16), .ADDR_W(16), .MAX_WAIT(15), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .halt_req(halt_req), .is_mem(is_mem), .is_store(is_store),
    .pc_addr(pc_addr), .ea(ea), .st_data(st_data), .bus(bus.master),
    .fetch(fetch), .execute(execute), .memory(memory), .ir_load(ir_load), .ir(ir),
    .reg_load(reg_load), .load_data(load_data), .halted(halted), .bus_err(bus_err),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        h, m, s, a;
    logic [15:0] pc, e, sd, din;
    logic [9:0]  ctl;
    logic [15:0] addr;
    logic [15:0] dout;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic h, m, s, a, input logic [15:0] pc, e, sd, din,
                              input logic [9:0] ctl, input logic [15:0] addr, dout,
                              input logic [31:0] ret);
    vec_t v;
    v.h = h; v.m = m; v.s = s; v.a = a;
    v.pc = pc; v.e = e; v.sd = sd; v.din = din;
    v.ctl = ctl; v.addr = addr; v.dout = dout; v.ret = ret;
    vecs.push_back(v);
  endfunction

  // {fetch, execute, memory, halted, bus_err, mem_req, mem_ren, mem_wen, ir_load, reg_load}
  function automatic logic [9:0] ctl_now();
    return {fetch, execute, memory, halted, bus_err,
            bus.mem_req, bus.mem_ren, bus.mem_wen, ir_load, reg_load};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passes++;
  endtask

  task automatic cyc(input logic h, m, s, a, input logic [15:0] pc, e, sd, din);
    @(negedge clk);
    halt_req = h; is_mem = m; is_store = s; bus.mem_ack = a;
    pc_addr = pc; ea = e; st_data = sd; bus.data_in = din;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    halt_req = 0; is_mem = 0; is_store = 0; bus.mem_ack = 0;
    pc_addr = 0; ea = 0; st_data = 0; bus.data_in = 0;
    #2;
    chk("reset ctl", 32'(ctl_now()), 32'h0);
    chk("reset address", 32'(bus.address), 32'h0);
    chk("reset retired", retired, 32'h0);
    chk("reset ir/load_data/data_out", {ir, load_data} | 32'(bus.data_out), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    int ok;
    rst = 1'b0;

    // Main sequence: zero-wait ADD, zero-wait LD, 3-wait fetch of ST, halt during ST wait.
    add(0,0,0,1, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 10'b0000000000, 16'h0000, 16'h0000, 0);
    add(0,0,0,1, 16'h0010, 16'h0000, 16'h0000, 16'h1234, 10'b1000011010, 16'h0010, 16'h0000, 0);
    add(0,0,0,1, 16'h0011, 16'h0000, 16'h0000, 16'h0000, 10'b0100000000, 16'h0000, 16'h0000, 0);
    add(0,0,0,1, 16'h0011, 16'h0000, 16'h0000, 16'h5678, 10'b1000011010, 16'h0011, 16'h0000, 1);
    add(0,1,0,1, 16'h0011, 16'h0200, 16'hAAAA, 16'h0000, 10'b0100000000, 16'h0000, 16'h0000, 1);
    add(0,0,0,1, 16'h0011, 16'h0000, 16'h0000, 16'hBEEF, 10'b0010011001, 16'h0200, 16'hAAAA, 1);
    add(0,0,0,0, 16'h0012, 16'h0000, 16'h0000, 16'h0000, 10'b1000011000, 16'h0012, 16'hAAAA, 2);
    add(0,0,0,0, 16'h0012, 16'h0000, 16'h0000, 16'h0000, 10'b1000011000, 16'h0012, 16'hAAAA, 2);
    add(0,0,0,0, 16'h0012, 16'h0000, 16'h0000, 16'h0000, 10'b1000011000, 16'h0012, 16'hAAAA, 2);
    add(0,0,0,1, 16'h0012, 16'h0000, 16'h0000, 16'h9ABC, 10'b1000011010, 16'h0012, 16'hAAAA, 2);
    add(0,1,1,0, 16'h0013, 16'h0300, 16'h5555, 16'h0000, 10'b0100000000, 16'h0000, 16'hAAAA, 2);
    add(1,0,0,0, 16'h0013, 16'h0000, 16'h0000, 16'h0000, 10'b0010010100, 16'h0300, 16'h5555, 2);
    add(1,0,0,1, 16'h0013, 16'h0000, 16'h0000, 16'hFFFF, 10'b0010010100, 16'h0300, 16'h5555, 2);
    add(1,0,0,0, 16'h0013, 16'h0000, 16'h0000, 16'h0000, 10'b0001000000, 16'h0000, 16'h5555, 3);
    add(0,0,0,1, 16'h0013, 16'h0000, 16'h0000, 16'h0000, 10'b0001000000, 16'h0000, 16'h5555, 3);
    add(0,0,0,0, 16'h0013, 16'h0000, 16'h0000, 16'h0000, 10'b1000011000, 16'h0013, 16'h5555, 3);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].a,
          vecs[i].pc, vecs[i].e, vecs[i].sd, vecs[i].din);
      chk($sformatf("vec%0d ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
      chk($sformatf("vec%0d address", i), 32'(bus.address), 32'(vecs[i].addr));
      chk($sformatf("vec%0d data_out", i), 32'(bus.data_out), 32'(vecs[i].dout));
      chk($sformatf("vec%0d retired", i), retired, vecs[i].ret);
    end
    chk("main ir", 32'(ir), 32'h9ABC);
    chk("main load_data", 32'(load_data), 32'hBEEF);

    // Timeout: no ack ever -> 16 request cycles, then sticky FAULT ignoring acks.
    do_reset();
    cyc(0,0,0,0, 16'h0040, 0, 0, 0);
    chk("timeout idle", 32'(ctl_now()), 32'h0);
    ok = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(0,0,0,0, 16'h0040, 0, 0, 0);
      if (bus.mem_req && fetch && !bus_err && bus.address == 16'h0040) ok++;
    end
    chk("timeout req cycles", ok, 16);
    cyc(0,0,0,0, 16'h0040, 0, 0, 0);
    chk("timeout fault ctl", 32'(ctl_now()), 32'(10'b0000100000));
    for (int i = 0; i < 3; i++) cyc(0,0,0,1, 16'h0040, 0, 0, 16'h7777);
    chk("fault sticky ctl", 32'(ctl_now()), 32'(10'b0000100000));
    chk("fault ir untouched", 32'(ir), 32'h0);

    // Boundary: ack on the 16th request cycle beats the timeout.
    do_reset();
    cyc(0,0,0,0, 16'h0050, 0, 0, 0);
    for (int i = 0; i < 15; i++) cyc(0,0,0,0, 16'h0050, 0, 0, 0);
    cyc(0,0,0,1, 16'h0050, 0, 0, 16'h1111);
    chk("boundary ack ctl", 32'(ctl_now()), 32'(10'b1000011010));
    cyc(0,0,0,0, 16'h0051, 0, 0, 0);
    chk("boundary execute ctl", 32'(ctl_now()), 32'(10'b0100000000));
    chk("boundary ir", 32'(ir), 32'h1111);

    // Reset mid-MEMORY: store waiting for ack, reset drops the request combinationally.
    cyc(0,0,0,1, 16'h0051, 0, 0, 16'h2222);
    cyc(0,1,1,0, 16'h0052, 16'h0500, 16'h7777, 0);
    cyc(0,0,0,0, 16'h0052, 0, 0, 0);
    cyc(0,0,0,0, 16'h0052, 0, 0, 0);
    chk("store wait ctl", 32'(ctl_now()), 32'(10'b0010010100));
    chk("store wait address", 32'(bus.address), 32'h0500);
    chk("store wait data_out", 32'(bus.data_out), 32'h7777);
    chk("store wait retired", retired, 32'h1);
    rst = 1'b0;
    #1;
    chk("async reset req/wen", {30'h0, bus.mem_req, bus.mem_wen}, 32'h0);
    chk("async reset retired", retired, 32'h0);
    chk("async reset data_out", 32'(bus.data_out), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    cyc(0,0,0,0, 16'h0060, 0, 0, 0);
    chk("post reset idle", 32'(ctl_now()), 32'h0);
    cyc(0,0,0,0, 16'h0060, 0, 0, 0);
    chk("post reset fetch", 32'(ctl_now()), 32'(10'b1000011000));
    chk("post reset address", 32'(bus.address), 32'h0060);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
